// File: rtl/mtr_seq.sv
// Speed/direction sequencer feeding the dual-channel PWM motor driver.
// Converts signed wheel commands into slew-limited (magnitude, rev) pairs with braked, dead-timed reversals.

module MtrSeqChan #(
    parameter int STEP     = 16,
    parameter int DEAD_CYC = 2048
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        estop_i,
    input  logic        tick_i,
    input  logic [11:0] cmd_i,
    output logic [10:0] spd_o,
    output logic        rev_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        DRIVE = 2'd0,
        BRAKE = 2'd1,
        DEAD  = 2'd2
    } chanState_e;

    localparam logic [10:0] STEP_V    = 11'(STEP);
    localparam logic [15:0] DEAD_LOAD = 16'(DEAD_CYC - 1);

    chanState_e  state_q, state_d;
    logic [10:0] spd_q, spd_d;
    logic        rev_q, rev_d;
    logic        busy_q, busy_d;
    logic [15:0] deadCnt_q, deadCnt_d;

    logic        tgtDir;
    logic [10:0] tgtMag;
    logic [10:0] cmdNeg;
    logic [10:0] upDiff, dnDiff;
    logic [10:0] upStep, dnStep, brakeStep;

    // A zero or disabled command keeps the current direction so it never triggers a flip.
    always_comb begin
        cmdNeg = ~cmd_i[10:0] + 11'd1;
        tgtDir = rev_q;
        tgtMag = '0;
        if (en_i && (cmd_i != 12'd0)) begin
            tgtDir = cmd_i[11];
            if (!cmd_i[11]) begin
                tgtMag = cmd_i[10:0];
            end else if (cmd_i[10:0] == 11'd0) begin
                tgtMag = 11'h7FF;
            end else begin
                tgtMag = cmdNeg;
            end
        end
    end

    always_comb begin
        upDiff    = tgtMag - spd_q;
        dnDiff    = spd_q - tgtMag;
        upStep    = (upDiff > STEP_V) ? STEP_V : upDiff;
        dnStep    = (dnDiff > STEP_V) ? STEP_V : dnDiff;
        brakeStep = (spd_q > STEP_V) ? STEP_V : spd_q;
    end

    always_comb begin
        state_d   = state_q;
        spd_d     = spd_q;
        rev_d     = rev_q;
        deadCnt_d = deadCnt_q;
        if (estop_i) begin
            state_d   = DEAD;
            spd_d     = '0;
            deadCnt_d = DEAD_LOAD;
        end else begin
            case (state_q)
                DRIVE: begin
                    if (tgtDir == rev_q) begin
                        if (tick_i) begin
                            if (tgtMag > spd_q) begin
                                spd_d = spd_q + upStep;
                            end else begin
                                spd_d = spd_q - dnStep;
                            end
                        end
                    end else if (spd_q != 11'd0) begin
                        state_d = BRAKE;
                    end else begin
                        state_d   = DEAD;
                        deadCnt_d = DEAD_LOAD;
                    end
                end
                BRAKE: begin
                    if (tgtDir == rev_q) begin
                        state_d = DRIVE;
                    end else if (spd_q == 11'd0) begin
                        state_d   = DEAD;
                        deadCnt_d = DEAD_LOAD;
                    end else if (tick_i) begin
                        spd_d = spd_q - brakeStep;
                    end
                end
                DEAD: begin
                    // Direction may only change here, with the wheel held at zero.
                    spd_d = '0;
                    if (deadCnt_q == 16'd0) begin
                        rev_d   = tgtDir;
                        state_d = DRIVE;
                    end else begin
                        deadCnt_d = deadCnt_q - 16'd1;
                    end
                end
                default: begin
                    state_d = DRIVE;
                    spd_d   = '0;
                end
            endcase
        end
        busy_d = (state_d != DRIVE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= DRIVE;
            spd_q     <= '0;
            rev_q     <= 1'b0;
            busy_q    <= 1'b0;
            deadCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            spd_q     <= spd_d;
            rev_q     <= rev_d;
            busy_q    <= busy_d;
            deadCnt_q <= deadCnt_d;
        end
    end

    assign spd_o  = spd_q;
    assign rev_o  = rev_q;
    assign busy_o = busy_q;

endmodule

module mtr_seq #(
    parameter int UPD_DIV  = 1024,
    parameter int STEP     = 16,
    parameter int DEAD_CYC = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        estop,
    input  logic [11:0] lft_cmd,
    input  logic [11:0] rght_cmd,
    output logic [10:0] lft_spd,
    output logic        lft_rev,
    output logic [10:0] rght_spd,
    output logic        rght_rev,
    output logic        lft_busy,
    output logic        rght_busy
);

    localparam int PW = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(UPD_DIV - 1);

    logic [PW-1:0] preCnt_q, preCnt_d;
    logic          tick;

    // Shared free-running update prescaler; deliberately ignores en and estop.
    always_comb begin
        tick     = (preCnt_q == PRE_MAX);
        preCnt_d = tick ? '0 : preCnt_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            preCnt_q <= '0;
        end else begin
            preCnt_q <= preCnt_d;
        end
    end

    MtrSeqChan #(
        .STEP     (STEP),
        .DEAD_CYC (DEAD_CYC)
    ) uLft (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .en_i    (en),
        .estop_i (estop),
        .tick_i  (tick),
        .cmd_i   (lft_cmd),
        .spd_o   (lft_spd),
        .rev_o   (lft_rev),
        .busy_o  (lft_busy)
    );

    MtrSeqChan #(
        .STEP     (STEP),
        .DEAD_CYC (DEAD_CYC)
    ) uRght (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .en_i    (en),
        .estop_i (estop),
        .tick_i  (tick),
        .cmd_i   (rght_cmd),
        .spd_o   (rght_spd),
        .rev_o   (rght_rev),
        .busy_o  (rght_busy)
    );

endmodule
